// File: rtl/pong_pkg.sv
// Shared sizes, types and helpers for the LED-matrix capture block.
package pong_pkg;

  localparam int MATRIX_DIM  = 16;
  localparam int ROW_IDX_W   = 4;
  localparam int FRAME_CNT_W = 8;
  localparam int SHIFT_CNT_W = 5;

  localparam logic [SHIFT_CNT_W-1:0] SHIFT_CNT_MAX = 5'd31;
  localparam logic [SHIFT_CNT_W-1:0] SHIFT_FULL    = 5'd16;
  localparam logic [ROW_IDX_W-1:0]   LAST_ROW      = 4'd15;

  typedef logic [MATRIX_DIM-1:0] row_word_t;

  typedef enum logic {
    BUF_A = 1'b0,
    BUF_B = 1'b1
  } buf_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [ROW_IDX_W-1:0] idx;
  } row_sel_t;

  // A row word is usable only when exactly one bit is set; idx is that bit.
  function automatic row_sel_t decodeRow(input row_word_t word);
    row_sel_t sel;
    int       ones;
    sel  = '0;
    ones = 0;
    for (int i = 0; i < MATRIX_DIM; i++) begin
      if (word[i]) begin
        ones++;
        sel.idx = ROW_IDX_W'(i);
      end
    end
    sel.valid = (ones == 1);
    return sel;
  endfunction

  function automatic logic [SHIFT_CNT_W-1:0] satInc(input logic [SHIFT_CNT_W-1:0] cnt);
    return (cnt == SHIFT_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mc_edge.sv
// Synchronizer chain (0-3 flops) followed by a rising-edge detector for one
// asynchronous matrix-driver input.
module mc_edge
  import pong_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic synced;
  logic prev_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = d_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d_i;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= synced;
    end
  end

  assign level_o = synced;
  assign rise_o  = synced & ~prev_q;

endmodule

// File: rtl/matrix_capture.sv
// Snoops the row/column shift registers of an LED-matrix driver and rebuilds
// the displayed image into a double-buffered 16x16 frame store.
module matrix_capture
  import pong_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk32mhz,
  input  logic                   reset,
  input  logic                   RCLK,
  input  logic                   RSDI,
  input  logic                   CCLK,
  input  logic                   CSDI,
  input  logic                   LE,
  input  logic [ROW_IDX_W-1:0]   rd_row,
  output logic [MATRIX_DIM-1:0]  rd_data,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   proto_err
);

  logic rclkRise, rclkLevel;
  logic rsdiRise, rsdiLevel;
  logic cclkRise, cclkLevel;
  logic csdiRise, csdiLevel;
  logic leRise, leLevel;

  mc_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edgeRclk (
    .clk_i(clk32mhz), .reset_i(reset), .d_i(RCLK), .level_o(rclkLevel), .rise_o(rclkRise)
  );
  mc_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edgeRsdi (
    .clk_i(clk32mhz), .reset_i(reset), .d_i(RSDI), .level_o(rsdiLevel), .rise_o(rsdiRise)
  );
  mc_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edgeCclk (
    .clk_i(clk32mhz), .reset_i(reset), .d_i(CCLK), .level_o(cclkLevel), .rise_o(cclkRise)
  );
  mc_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edgeCsdi (
    .clk_i(clk32mhz), .reset_i(reset), .d_i(CSDI), .level_o(csdiLevel), .rise_o(csdiRise)
  );
  mc_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edgeLe (
    .clk_i(clk32mhz), .reset_i(reset), .d_i(LE), .level_o(leLevel), .rise_o(leRise)
  );

  // Clocks only need their edges and data lines only their levels.
  logic unused_edgeOutputs;
  assign unused_edgeOutputs = ^{rclkLevel, rsdiRise, cclkLevel, csdiRise, leLevel};

  row_word_t                rowShift_q, rowShift_d;
  row_word_t                colShift_q, colShift_d;
  logic [SHIFT_CNT_W-1:0]   rowCnt_q, rowCnt_d;
  logic [SHIFT_CNT_W-1:0]   colCnt_q, colCnt_d;
  buf_sel_e                 dispSel_q, dispSel_d;
  logic                     err_q, err_d;
  logic [FRAME_CNT_W-1:0]   frameCnt_q, frameCnt_d;
  logic                     swapPend_q, swapPend_d;
  logic                     done_q, done_d;
  row_word_t                rdData_q, rdData_d;
  row_word_t                frameBuf_q [2][MATRIX_DIM];

  row_sel_t rowSel;
  logic     commit;
  logic     swap;
  logic     dispIdx;
  logic     wrIdx;

  assign rowSel  = decodeRow(rowShift_q);
  assign commit  = leRise && rowSel.valid && (rowCnt_q == SHIFT_FULL) && (colCnt_q == SHIFT_FULL);
  assign swap    = commit && (rowSel.idx == LAST_ROW);
  assign dispIdx = (dispSel_q == BUF_B);
  assign wrIdx   = ~dispIdx;

  // The latch clears the counters first so a coincident shift edge counts as 1.
  always_comb begin
    rowShift_d = rowShift_q;
    colShift_d = colShift_q;
    rowCnt_d   = rowCnt_q;
    colCnt_d   = colCnt_q;
    dispSel_d  = dispSel_q;
    err_d      = err_q;
    frameCnt_d = frameCnt_q;
    swapPend_d = swap;
    done_d     = swapPend_q;
    rdData_d   = frameBuf_q[dispIdx][rd_row];

    if (leRise) begin
      rowCnt_d = '0;
      colCnt_d = '0;
      if (!commit) begin
        err_d = 1'b1;
      end
    end

    if (rclkRise) begin
      rowShift_d = {rowShift_q[MATRIX_DIM-2:0], rsdiLevel};
      rowCnt_d   = satInc(rowCnt_d);
    end

    if (cclkRise) begin
      colShift_d = {colShift_q[MATRIX_DIM-2:0], csdiLevel};
      colCnt_d   = satInc(colCnt_d);
    end

    if (swap) begin
      dispSel_d  = (dispSel_q == BUF_A) ? BUF_B : BUF_A;
      frameCnt_d = frameCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk32mhz) begin
    if (reset) begin
      rowShift_q <= '0;
      colShift_q <= '0;
      rowCnt_q   <= '0;
      colCnt_q   <= '0;
      dispSel_q  <= BUF_A;
      err_q      <= 1'b0;
      frameCnt_q <= '0;
      swapPend_q <= 1'b0;
      done_q     <= 1'b0;
      rdData_q   <= '0;
    end else begin
      rowShift_q <= rowShift_d;
      colShift_q <= colShift_d;
      rowCnt_q   <= rowCnt_d;
      colCnt_q   <= colCnt_d;
      dispSel_q  <= dispSel_d;
      err_q      <= err_d;
      frameCnt_q <= frameCnt_d;
      swapPend_q <= swapPend_d;
      done_q     <= done_d;
      rdData_q   <= rdData_d;
    end
  end

  // Rows go into the buffer not on display; the image only appears on a swap.
  always_ff @(posedge clk32mhz) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < MATRIX_DIM; r++) begin
          frameBuf_q[b][r] <= '0;
        end
      end
    end else if (commit) begin
      frameBuf_q[wrIdx][rowSel.idx] <= colShift_q;
    end
  end

  assign rd_data     = rdData_q;
  assign frame_done  = done_q;
  assign frame_count = frameCnt_q;
  assign proto_err   = err_q;

endmodule
